note_detector: RTL and testbench

//  Inverse of the note-to-frequency lookup. Measures the frequency of a 1-bit audio

---
 rtl/note_detector.sv | 183 ++++++++++++++++++
 tb/tb_note_detector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/note_detector.sv
// Frequency counter and nearest-note finder for a 1-bit audio input.
// Counts rising edges over a gate window, then scans the 108-entry equal-tempered table for the closest pitch.
module note_detector #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int GATE_SHIFT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sig_in,
  output logic [15:0] frequency,
  output logic [3:0]  note,
  output logic [3:0]  octave,
  output logic        note_valid,
  output logic        valid
);

  localparam int DATA_W  = 16;
  localparam int GW      = $clog2(GATE_CYCLES + 1);
  localparam int LAST_IX = 107;

  typedef enum logic [1:0] {MEASURE, SEARCH, DONE} state_t;

  state_t            state_q, state_d;
  logic              sync_q, sync_qq;
  logic [GW-1:0]     gate_cnt;
  logic [DATA_W-1:0] edge_cnt;
  logic [DATA_W-1:0] edge_inc;
  logic [DATA_W-1:0] meas_q;
  logic [6:0]        idx_q;
  logic [6:0]        best_idx;
  logic [DATA_W-1:0] best_diff;
  logic [DATA_W-1:0] tab_hz;
  logic [DATA_W-1:0] cand_diff;
  logic [6:0]        final_idx;
  logic              rise, gate_last, search_last, take;
  logic              vld_p0;

  // Rounded equal-tempered frequencies, idx = 12*octave + note (C0 .. B8).
  function automatic logic [DATA_W-1:0] note_hz(input logic [6:0] ix);
    logic [DATA_W-1:0] hz;
    hz = '0;
    case (ix)
      7'd0:   hz = 16'd16;   7'd1:   hz = 16'd17;   7'd2:   hz = 16'd18;   7'd3:   hz = 16'd19;
      7'd4:   hz = 16'd21;   7'd5:   hz = 16'd22;   7'd6:   hz = 16'd23;   7'd7:   hz = 16'd24;
      7'd8:   hz = 16'd26;   7'd9:   hz = 16'd28;   7'd10:  hz = 16'd29;   7'd11:  hz = 16'd31;
      7'd12:  hz = 16'd33;   7'd13:  hz = 16'd35;   7'd14:  hz = 16'd37;   7'd15:  hz = 16'd39;
      7'd16:  hz = 16'd41;   7'd17:  hz = 16'd44;   7'd18:  hz = 16'd46;   7'd19:  hz = 16'd49;
      7'd20:  hz = 16'd52;   7'd21:  hz = 16'd55;   7'd22:  hz = 16'd58;   7'd23:  hz = 16'd62;
      7'd24:  hz = 16'd65;   7'd25:  hz = 16'd69;   7'd26:  hz = 16'd73;   7'd27:  hz = 16'd78;
      7'd28:  hz = 16'd82;   7'd29:  hz = 16'd87;   7'd30:  hz = 16'd92;   7'd31:  hz = 16'd98;
      7'd32:  hz = 16'd104;  7'd33:  hz = 16'd110;  7'd34:  hz = 16'd117;  7'd35:  hz = 16'd123;
      7'd36:  hz = 16'd131;  7'd37:  hz = 16'd139;  7'd38:  hz = 16'd147;  7'd39:  hz = 16'd156;
      7'd40:  hz = 16'd165;  7'd41:  hz = 16'd175;  7'd42:  hz = 16'd185;  7'd43:  hz = 16'd196;
      7'd44:  hz = 16'd208;  7'd45:  hz = 16'd220;  7'd46:  hz = 16'd233;  7'd47:  hz = 16'd247;
      7'd48:  hz = 16'd262;  7'd49:  hz = 16'd277;  7'd50:  hz = 16'd294;  7'd51:  hz = 16'd311;
      7'd52:  hz = 16'd330;  7'd53:  hz = 16'd349;  7'd54:  hz = 16'd370;  7'd55:  hz = 16'd392;
      7'd56:  hz = 16'd415;  7'd57:  hz = 16'd440;  7'd58:  hz = 16'd466;  7'd59:  hz = 16'd494;
      7'd60:  hz = 16'd523;  7'd61:  hz = 16'd554;  7'd62:  hz = 16'd587;  7'd63:  hz = 16'd622;
      7'd64:  hz = 16'd659;  7'd65:  hz = 16'd698;  7'd66:  hz = 16'd740;  7'd67:  hz = 16'd784;
      7'd68:  hz = 16'd831;  7'd69:  hz = 16'd880;  7'd70:  hz = 16'd932;  7'd71:  hz = 16'd988;
      7'd72:  hz = 16'd1047; 7'd73:  hz = 16'd1109; 7'd74:  hz = 16'd1175; 7'd75:  hz = 16'd1245;
      7'd76:  hz = 16'd1319; 7'd77:  hz = 16'd1397; 7'd78:  hz = 16'd1480; 7'd79:  hz = 16'd1568;
      7'd80:  hz = 16'd1661; 7'd81:  hz = 16'd1760; 7'd82:  hz = 16'd1865; 7'd83:  hz = 16'd1976;
      7'd84:  hz = 16'd2093; 7'd85:  hz = 16'd2217; 7'd86:  hz = 16'd2349; 7'd87:  hz = 16'd2489;
      7'd88:  hz = 16'd2637; 7'd89:  hz = 16'd2794; 7'd90:  hz = 16'd2960; 7'd91:  hz = 16'd3136;
      7'd92:  hz = 16'd3322; 7'd93:  hz = 16'd3520; 7'd94:  hz = 16'd3729; 7'd95:  hz = 16'd3951;
      7'd96:  hz = 16'd4186; 7'd97:  hz = 16'd4435; 7'd98:  hz = 16'd4699; 7'd99:  hz = 16'd4978;
      7'd100: hz = 16'd5274; 7'd101: hz = 16'd5588; 7'd102: hz = 16'd5920; 7'd103: hz = 16'd6272;
      7'd104: hz = 16'd6645; 7'd105: hz = 16'd7040; 7'd106: hz = 16'd7459; 7'd107: hz = 16'd7902;
      default: hz = '0;
    endcase
    return hz;
  endfunction

  // Scale the edge count to Hz, clamping at full scale.
  function automatic logic [DATA_W-1:0] sat_shift(input logic [DATA_W-1:0] cnt);
    logic [2*DATA_W-1:0] wide;
    wide = {{DATA_W{1'b0}}, cnt} << GATE_SHIFT;
    return (|wide[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}} : wide[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DATA_W] ? DATA_W'(-d) : d[DATA_W-1:0];
  endfunction

  assign rise        = sync_q & ~sync_qq;
  assign gate_last   = (gate_cnt == GW'(GATE_CYCLES - 1));
  assign search_last = (idx_q == 7'(LAST_IX));
  assign edge_inc    = (rise && (edge_cnt != {DATA_W{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;

  // Candidate for this table slot; strict less-than keeps the lower index on ties.
  assign tab_hz    = note_hz(idx_q);
  assign cand_diff = abs_diff(tab_hz, meas_q);
  assign take      = (idx_q == 7'd0) || (cand_diff < best_diff);
  assign final_idx = take ? idx_q : best_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEASURE: if (gate_last)   state_d = SEARCH;
      SEARCH:  if (search_last) state_d = DONE;
      DONE:                     state_d = MEASURE;
      default:                  state_d = MEASURE;
    endcase
    if (!enable) state_d = MEASURE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEASURE;
      sync_q     <= 1'b0;
      sync_qq    <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      idx_q      <= '0;
      best_idx   <= '0;
      best_diff  <= '0;
      meas_q     <= '0;
      frequency  <= '0;
      note       <= '0;
      octave     <= '0;
      note_valid <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sig_in;
      sync_qq <= sync_q;
      vld_p0  <= 1'b0;
      if (!enable) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        idx_q    <= '0;
      end else begin
        case (state_q)
          MEASURE: begin
            if (gate_last) begin
              meas_q   <= sat_shift(edge_inc);
              gate_cnt <= '0;
              edge_cnt <= '0;
              idx_q    <= '0;
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
              edge_cnt <= edge_inc;
            end
          end
          SEARCH: begin
            if (take) begin
              best_idx  <= idx_q;
              best_diff <= cand_diff;
            end
            // Last slot: publish directly so the values land together with valid.
            if (search_last) begin
              idx_q     <= '0;
              frequency <= meas_q;
              vld_p0    <= 1'b1;
              if (meas_q != '0) begin
                note_valid <= 1'b1;
                note       <= 4'(final_idx % 7'd12);
                octave     <= 4'(final_idx / 7'd12);
              end else begin
                note_valid <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 7'd1;
            end
          end
          default: begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            idx_q    <= '0;
          end
        endcase
      end
    end
  end

  assign valid = vld_p0;

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector: table of gate windows plus reset/enable/saturation sequences.
module tb_note_detector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, sig_in = 1'b0;
  logic en2 = 1'b0, sig2 = 1'b0;
  logic en3 = 1'b0, sig3 = 1'b0;
  logic [15:0] freq1, freq2, freq3;
  logic [3:0]  note1, note2, note3, oct1, oct2, oct3;
  logic        nv1, nv2, nv3, val1, val2, val3;

  int total = 0;
  int passed = 0;
  int vcnt = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  note_detector #(.GATE_CYCLES(1000), .GATE_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .frequency(freq1), .note(note1), .octave(oct1), .note_valid(nv1), .valid(val1));

  note_detector #(.GATE_CYCLES(20000), .GATE_SHIFT(0)) u_dense (
    .clk(clk), .reset(reset), .enable(en2), .sig_in(sig2),
    .frequency(freq2), .note(note2), .octave(oct2), .note_valid(nv2), .valid(val2));

  note_detector #(.GATE_CYCLES(12000), .GATE_SHIFT(4)) u_sat (
    .clk(clk), .reset(reset), .enable(en3), .sig_in(sig3),
    .frequency(freq3), .note(note3), .octave(oct3), .note_valid(nv3), .valid(val3));

  always @(posedge clk) if (val1) vcnt <= vcnt + 1;

  typedef struct {
    int edges;
    int freq;
    int note;
    int oct;
    int nv;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        1: sig2 = 1'b1;
        2: sig3 = 1'b1;
        default: sig_in = 1'b1;
      endcase
      @(negedge clk);
      sig_in = 1'b0; sig2 = 1'b0; sig3 = 1'b0;
      @(negedge clk);
    end
  endtask

  // Called in cycle 0 of a window; returns in cycle 0 of the next one.
  task automatic run_window(input vec_t v, input string tag);
    pulses(0, v.edges);
    step(1107 - 2 * v.edges);
    chk({tag, " valid_before"}, val1, 0);
    step(1);
    chk({tag, " valid"}, val1, 1);
    chk({tag, " frequency"}, freq1, v.freq);
    chk({tag, " note"}, note1, v.note);
    chk({tag, " octave"}, oct1, v.oct);
    chk({tag, " note_valid"}, nv1, v.nv);
    exp_pulses++;
    step(1);
    chk({tag, " valid_after"}, val1, 0);
  endtask

  initial begin
    vecs[0] = '{440, 440, 9, 4, 1};
    vecs[1] = '{450, 450, 9, 4, 1};
    vecs[2] = '{20, 20, 3, 0, 1};
    vecs[3] = '{440, 440, 9, 4, 1};
    vecs[4] = '{0, 0, 9, 4, 0};
    vecs[5] = '{1, 1, 0, 0, 1};
    vecs[6] = '{466, 466, 10, 4, 1};
    vecs[7] = '{17, 17, 1, 0, 1};

    enable = 1'b1;
    step(3);
    reset = 1'b0;
    chk("reset frequency", freq1, 0);
    chk("reset note", note1, 0);
    chk("reset octave", oct1, 0);
    chk("reset note_valid", nv1, 0);
    chk("reset valid", val1, 0);

    for (int i = 0; i < 8; i++) run_window(vecs[i], $sformatf("vec%0d", i));
    chk("pulse count table", vcnt, exp_pulses);

    // Reset landing mid-SEARCH suppresses the pulse and clears outputs.
    pulses(0, 300);
    step(450);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("midsearch reset frequency", freq1, 0);
    chk("midsearch reset note", note1, 0);
    chk("midsearch reset octave", oct1, 0);
    chk("midsearch reset note_valid", nv1, 0);
    chk("midsearch reset valid", val1, 0);
    chk("midsearch pulse count", vcnt, exp_pulses);
    run_window('{262, 262, 0, 4, 1}, "after_reset");

    // Enable dropped at cycle 500 for 10 cycles; restarted window with edges also during SEARCH.
    pulses(0, 100);
    step(300);
    enable = 1'b0;
    step(10);
    enable = 1'b1;
    pulses(0, 200);
    step(600);
    pulses(0, 40);
    step(27);
    chk("restart valid_before", val1, 0);
    chk("restart no stale pulse", vcnt, exp_pulses);
    step(1);
    chk("restart valid", val1, 1);
    chk("restart frequency", freq1, 200);
    chk("restart note", note1, 7);
    chk("restart octave", oct1, 3);
    chk("restart note_valid", nv1, 1);
    exp_pulses++;
    step(1);
    chk("restart pulse count", vcnt, exp_pulses);

    // Dense stimulus above the top of the table.
    enable = 1'b0;
    en2 = 1'b1;
    pulses(1, 9000);
    step(2107);
    chk("dense valid_before", val2, 0);
    step(1);
    chk("dense valid", val2, 1);
    chk("dense frequency", freq2, 9000);
    chk("dense note", note2, 11);
    chk("dense octave", oct2, 8);
    chk("dense note_valid", nv2, 1);
    en2 = 1'b0;

    // Shifted count overflowing 16 bits saturates.
    en3 = 1'b1;
    pulses(2, 5000);
    step(2107);
    chk("sat valid_before", val3, 0);
    step(1);
    chk("sat valid", val3, 1);
    chk("sat frequency", freq3, 65535);
    chk("sat note", note3, 11);
    chk("sat octave", oct3, 8);
    chk("sat note_valid", nv3, 1);
    en3 = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
